// File: rtl/mem_if_pkg.sv
// Shared encodings and types for the data-memory responder.
// Size codes, FSM states, request bundle, alignment helper.
package mem_if_pkg;

  localparam logic [1:0] SIZE_B   = 2'b00;
  localparam logic [1:0] SIZE_H   = 2'b01;
  localparam logic [1:0] SIZE_W   = 2'b10;
  localparam logic [1:0] SIZE_RSV = 2'b11;

  localparam int LAT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  typedef struct packed {
    logic        write;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] data;
  } mem_req_t;

  function automatic logic misaligned(
    input logic [1:0] size,
    input logic [1:0] a
  );
    logic m;
    case (size)
      SIZE_B:  m = 1'b0;
      SIZE_H:  m = a[0];
      SIZE_W:  m = |a;
      default: m = 1'b1;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lane_steer.sv
// Byte/halfword lane steering for a little-endian 32-bit word.
// Store merge and right-aligned, zero-extended load extract.
module lane_steer
  import mem_if_pkg::*;
(
  input  logic [31:0] st_word,
  input  logic [1:0]  st_addr,
  input  logic [1:0]  st_size,
  input  logic [31:0] st_data,
  output logic [31:0] st_merged,
  input  logic [31:0] ld_word,
  input  logic [1:0]  ld_addr,
  input  logic [1:0]  ld_size,
  output logic [31:0] ld_data
);

  logic [31:0] ld_shift;

  // Replace only the selected lanes of the stored word
  always_comb begin
    st_merged = st_word;
    case (st_size)
      SIZE_B: st_merged[{st_addr, 3'b000} +: 8] = st_data[7:0];
      SIZE_H: st_merged[{st_addr[1], 4'b0000} +: 16] = st_data[15:0];
      SIZE_W: st_merged = st_data;
      default: st_merged = st_word;
    endcase
  end

  // Shift the addressed lanes down to bit 0 and clear the rest
  always_comb begin
    ld_shift = ld_word >> {ld_addr, 3'b000};
    ld_data  = '0;
    case (ld_size)
      SIZE_B: ld_data = {24'h0, ld_shift[7:0]};
      SIZE_H: ld_data = {16'h0, ld_shift[15:0]};
      SIZE_W: ld_data = ld_word;
      default: ld_data = '0;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: request latch, wait FSM, word RAM.
// Returns a one-cycle ready with zero-extended load data.
module data_mem_responder
  import mem_if_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mreq,
  input  logic        write,
  input  logic [31:0] dad,
  input  logic [1:0]  size,
  input  logic [31:0] ddt_in,
  output logic [31:0] ddt_out,
  output logic        ready,
  output logic        busy,
  output logic        err
);

  localparam int DEPTH = 2 ** (ADDR_W - 2);
  localparam logic [LAT_W-1:0] LAT_LD =
    (LATENCY == 0) ? '0 : LAT_W'(LATENCY - 1);

  state_e            state_q, state_d;
  logic [LAT_W-1:0]  cnt_q, cnt_d;
  mem_req_t          req_q, req_d;
  logic [31:0]       ddt_q, ddt_d;
  logic              err_q, err_d;
  logic              resp_go;
  logic              mem_we;

  logic [31:0]       mem [DEPTH];
  logic [ADDR_W-3:0] st_idx, ld_idx;
  logic [31:0]       st_merged, ld_data;
  logic              unused_addr_hi;

  assign st_idx = req_q.addr[ADDR_W-1:2];
  assign ld_idx = req_d.addr[ADDR_W-1:2];
  assign unused_addr_hi = ^req_q.addr[31:ADDR_W];

  lane_steer u_lane (
    .st_word  (mem[st_idx]),
    .st_addr  (req_q.addr[1:0]),
    .st_size  (req_q.size),
    .st_data  (req_q.data),
    .st_merged(st_merged),
    .ld_word  (mem[ld_idx]),
    .ld_addr  (req_d.addr[1:0]),
    .ld_size  (req_d.size),
    .ld_data  (ld_data)
  );

  // Next state, counter, latch and response data
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    ddt_d   = '0;
    err_d   = 1'b0;
    resp_go = 1'b0;
    mem_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (mreq) begin
          req_d.write = write;
          req_d.size  = size;
          req_d.addr  = dad;
          req_d.data  = ddt_in;
          if (LATENCY == 0) begin
            state_d = RESP;
            resp_go = 1'b1;
          end else begin
            cnt_d   = LAT_LD;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
          resp_go = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
        mem_we  = req_q.write & ~err_q;
      end
      default: state_d = IDLE;
    endcase
    if (resp_go) begin
      err_d = misaligned(req_d.size, req_d.addr[1:0]);
      ddt_d = (!req_d.write && !err_d) ? ld_data : '0;
    end
  end

  // Control and response registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      ddt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      ddt_q   <= ddt_d;
      err_q   <= err_d;
    end
  end

  // Store merge at the end of the response cycle
  always_ff @(posedge clk) begin
    if (mem_we) mem[st_idx] <= st_merged;
  end

  assign ddt_out = ddt_q;
  assign err     = err_q;
  assign ready   = (state_q == RESP);
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: vector table, corner sequences,
// and random traffic against a byte-array memory model.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mreq2 = 1'b0;
  logic        mreq0 = 1'b0;
  logic        write = 1'b0;
  logic [31:0] dad = '0;
  logic [1:0]  size = '0;
  logic [31:0] ddt_in = '0;
  logic [31:0] ddt_out2, ddt_out0;
  logic        ready2, ready0, busy2, busy0, err2, err0;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] mb [2][256];

  typedef struct {
    int          sel;
    bit          wr;
    logic [1:0]  sz;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] ed;
    logic        ee;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  data_mem_responder #(.ADDR_W(16), .LATENCY(2)) dut (
    .clk(clk), .rst(rst), .mreq(mreq2), .write(write), .dad(dad),
    .size(size), .ddt_in(ddt_in), .ddt_out(ddt_out2),
    .ready(ready2), .busy(busy2), .err(err2)
  );

  data_mem_responder #(.ADDR_W(16), .LATENCY(0)) dut0 (
    .clk(clk), .rst(rst), .mreq(mreq0), .write(write), .dad(dad),
    .size(size), .ddt_in(ddt_in), .ddt_out(ddt_out0),
    .ready(ready0), .busy(busy0), .err(err0)
  );

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic do_req(input int sel, input bit wr, input logic [1:0] sz,
                        input logic [31:0] a, input logic [31:0] d,
                        input bit hold, input logic [31:0] alt,
                        output logic [31:0] rd, output logic re,
                        output int lat);
    bit got;
    @(negedge clk);
    write = wr; size = sz; dad = a; ddt_in = d;
    if (sel == 1) mreq0 = 1'b1; else mreq2 = 1'b1;
    @(posedge clk);
    #1;
    if (hold) dad = alt;
    else begin mreq0 = 1'b0; mreq2 = 1'b0; end
    got = 1'b0; rd = '0; re = 1'b0; lat = 99;
    for (int i = 1; i <= 40 && !got; i++) begin
      @(negedge clk);
      if ((sel == 1) ? ready0 : ready2) begin
        got = 1'b1;
        lat = i;
        rd = (sel == 1) ? ddt_out0 : ddt_out2;
        re = (sel == 1) ? err0 : err2;
      end
    end
  endtask

  task automatic model(input int s, input bit wr, input logic [1:0] sz,
                       input int off, input logic [31:0] d,
                       output logic [31:0] ed, output logic ee);
    int n;
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    ee = (sz == 2'd3) || ((off % n) != 0);
    ed = '0;
    if (!ee) begin
      for (int i = 0; i < n; i++) begin
        if (wr) mb[s][off + i] = d[8 * i +: 8];
        else ed = ed | (32'(mb[s][off + i]) << (8 * i));
      end
    end
  endtask

  function automatic vec_t mk(int s, bit w, logic [1:0] z, logic [31:0] a,
                              logic [31:0] d, logic [31:0] ed, logic ee);
    vec_t v;
    v.sel = s; v.wr = w; v.sz = z; v.a = a; v.d = d; v.ed = ed; v.ee = ee;
    return v;
  endfunction

  initial begin
    logic [31:0] rd, ed, d;
    logic        re, ee;
    int          lat, off;
    bit          wr;
    logic [1:0]  sz;

    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("reset_ready", 32'(ready2), 32'd0);
    chk("reset_busy", 32'(busy2), 32'd0);
    chk("reset_err", 32'(err2), 32'd0);
    chk("reset_ddt", ddt_out2, 32'd0);

    tbl.push_back(mk(0, 1, 2'b10, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0));
    tbl.push_back(mk(0, 0, 2'b10, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0));
    tbl.push_back(mk(0, 0, 2'b10, 32'h10010, 32'h0, 32'hDEADBEEF, 1'b0));
    tbl.push_back(mk(0, 1, 2'b10, 32'h20, 32'h11223344, 32'h0, 1'b0));
    tbl.push_back(mk(0, 1, 2'b00, 32'h22, 32'h555555AA, 32'h0, 1'b0));
    tbl.push_back(mk(0, 0, 2'b10, 32'h20, 32'h0, 32'h11AA3344, 1'b0));
    tbl.push_back(mk(0, 1, 2'b01, 32'h20, 32'h7777BEEF, 32'h0, 1'b0));
    tbl.push_back(mk(0, 0, 2'b10, 32'h20, 32'h0, 32'h11AABEEF, 1'b0));
    tbl.push_back(mk(0, 0, 2'b00, 32'h23, 32'h0, 32'h00000011, 1'b0));
    tbl.push_back(mk(0, 0, 2'b01, 32'h22, 32'h0, 32'h000011AA, 1'b0));
    tbl.push_back(mk(0, 1, 2'b10, 32'h24, 32'hCAFEF00D, 32'h0, 1'b0));
    tbl.push_back(mk(0, 0, 2'b10, 32'h21, 32'h0, 32'h0, 1'b1));
    tbl.push_back(mk(0, 1, 2'b01, 32'h25, 32'h1234, 32'h0, 1'b1));
    tbl.push_back(mk(0, 1, 2'b11, 32'h24, 32'h0, 32'h0, 1'b1));
    tbl.push_back(mk(0, 0, 2'b10, 32'h24, 32'h0, 32'hCAFEF00D, 1'b0));
    tbl.push_back(mk(0, 1, 2'b10, 32'h40, 32'h55, 32'h0, 1'b0));
    tbl.push_back(mk(0, 1, 2'b10, 32'h44, 32'h66, 32'h0, 1'b0));
    tbl.push_back(mk(0, 1, 2'b10, 32'h30, 32'h0, 32'h0, 1'b0));
    tbl.push_back(mk(1, 1, 2'b10, 32'h50, 32'h01020304, 32'h0, 1'b0));
    tbl.push_back(mk(1, 0, 2'b00, 32'h52, 32'h0, 32'h02, 1'b0));
    tbl.push_back(mk(1, 0, 2'b01, 32'h51, 32'h0, 32'h0, 1'b1));
    tbl.push_back(mk(1, 0, 2'b10, 32'h50, 32'h0, 32'h01020304, 1'b0));

    foreach (tbl[k]) begin
      do_req(tbl[k].sel, tbl[k].wr, tbl[k].sz, tbl[k].a, tbl[k].d,
             1'b0, 32'h0, rd, re, lat);
      chk($sformatf("vec%0d_lat", k), 32'(lat),
          (tbl[k].sel == 1) ? 32'd1 : 32'd3);
      chk($sformatf("vec%0d_data", k), rd, tbl[k].ed);
      chk($sformatf("vec%0d_err", k), 32'(re), 32'(tbl[k].ee));
    end

    // mreq held through WAIT and RESP with a changed address
    do_req(0, 1'b0, 2'b10, 32'h40, 32'h0, 1'b1, 32'h44, rd, re, lat);
    chk("hold_lat", 32'(lat), 32'd3);
    chk("hold_data", rd, 32'h55);
    @(negedge clk);
    chk("hold_rdy_off", 32'(ready2), 32'd0);
    chk("hold_no_accept", 32'(busy2), 32'd0);
    mreq2 = 1'b0;

    // busy during WAIT, then reset abandons a store
    @(negedge clk);
    write = 1'b1; size = 2'b10; dad = 32'h30; ddt_in = 32'hFFFFFFFF;
    mreq2 = 1'b1;
    @(posedge clk);
    #1 mreq2 = 1'b0;
    @(negedge clk);
    chk("wait_busy", 32'(busy2), 32'd1);
    chk("wait_ready", 32'(ready2), 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_busy", 32'(busy2), 32'd0);
    chk("rst_ready", 32'(ready2), 32'd0);
    repeat (4) begin
      @(negedge clk);
      chk("rst_hold_ready", 32'(ready2), 32'd0);
    end
    rst = 1'b1;
    do_req(0, 1'b0, 2'b10, 32'h30, 32'h0, 1'b0, 32'h0, rd, re, lat);
    chk("rst_load_lat", 32'(lat), 32'd3);
    chk("rst_load_data", rd, 32'h0);

    // random traffic on region 0x100..0x13F of each build
    for (int s = 0; s < 2; s++) begin
      for (int w = 0; w < 16; w++) begin
        d = $urandom;
        model(s, 1'b1, 2'b10, w * 4, d, ed, ee);
        do_req(s, 1'b1, 2'b10, 32'h100 + 32'(w * 4), d, 1'b0, 32'h0,
               rd, re, lat);
      end
      for (int n = 0; n < 150; n++) begin
        wr  = 1'($urandom_range(0, 1));
        sz  = 2'($urandom_range(0, 3));
        off = $urandom_range(0, 63);
        d   = $urandom;
        model(s, wr, sz, off, d, ed, ee);
        do_req(s, wr, sz, 32'h100 + 32'(off), d, 1'b0, 32'h0, rd, re, lat);
        chk($sformatf("rnd%0d_%0d_lat", s, n), 32'(lat),
            (s == 1) ? 32'd1 : 32'd3);
        chk($sformatf("rnd%0d_%0d_data", s, n), rd, ed);
        chk($sformatf("rnd%0d_%0d_err", s, n), 32'(re), 32'(ee));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Responder end of the core's data-memory bus. It accepts the MEM-stage request (mreq, WRITE, DAD address, DDT store data) and returns DDT load data with a ready strobe after a configurable wait.
- It holds a word-organised RAM and performs byte and halfword lane steering for stores and loads.
- Sign extension of load data stays in the core; this block returns loads zero-extended.
- It sits between the core datapath and the board/testbench and replaces the ideal zero-wait memory model.

Parameters:
- ADDR_W, 16, byte-address bits decoded; RAM depth is 2**(ADDR_W-2) words; upper DAD bits are ignored (aliasing).
- LATENCY, 2, wait cycles between request acceptance and the response cycle; legal range 0..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- mreq  input  1  request strobe, sampled only in IDLE.
- write  input  1  1 = store, 0 = load; qualified by mreq.
- dad  input  32  byte address.
- size  input  2  access size: 00 = byte, 01 = half, 10 = word, 11 = reserved (treated as misaligned).
- ddt_in  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- ddt_out  output  32  load data, right-aligned and zero-extended; valid only while ready=1.
- ready  output  1  one-cycle response strobe for both load and store.
- busy  output  1  high from the acceptance edge until the end of the RESP cycle.
- err  output  1  misalignment flag; valid with ready.

Behaviour:
- Reset (rst low, asynchronous):
  - FSM goes to IDLE; wait counter = 0; ddt_out = 0; ready = 0; busy = 0; err = 0.
  - RAM contents are not cleared.
  - A reset in WAIT or RESP abandons the access; no RAM write occurs.
- FSM states: IDLE, WAIT, RESP.
  - IDLE, mreq=1 at a rising edge: latch dad, write, size and ddt_in; set busy.
    - LATENCY=0: go to RESP.
    - Otherwise: load counter with LATENCY-1 and go to WAIT.
  - WAIT: decrement counter each cycle; at 0, go to RESP. The request is accepted at edge N; ready is high during cycle N+LATENCY+1.
  - RESP: ready=1 for exactly one cycle, then IDLE. mreq high during RESP is not accepted; a new request is accepted earliest on the edge that enters IDLE + 1 cycle, i.e. the core must re-present the request after ready.
- mreq while busy is ignored, and the latched request is unchanged.
- Alignment check (on latched values):
  - half requires dad[0]=0.
  - word requires dad[1:0]=00.
  - size 11 is always misaligned.
  - Byte accesses are always aligned.
- Misaligned access:
  - No RAM write.
  - ddt_out = 0, err = 1 in RESP.
  - Still a normal RESP handshake.
- Store, aligned: in the RESP cycle, merge the selected lanes into the word at dad[ADDR_W-1:2]. Lane rules:
  - byte at lane dad[1:0].
  - half at lanes {dad[1],0}.
  - word uses all 4 lanes.
  - Unselected lanes are unchanged.
  - ddt_out = 0 for stores.
- Load, aligned:
  - The RAM word is read in the RESP cycle.
  - ddt_out = lane(s) shifted to the LSBs, with upper bits 0.
  - Registered so ddt_out is stable throughout the RESP cycle.
- Outside RESP, ddt_out holds 0 and err = 0.
- Byte order is little-endian: lane 0 = bits [7:0].
- Read-after-write: a load accepted after a store's RESP returns the stored value.

Decomposition:
- Package mem_if_pkg holds:
  - SIZE_B / SIZE_H / SIZE_W / SIZE_RSV encodings.
  - State enum {IDLE, WAIT, RESP}.
  - LAT_W = 4 counter width constant.
- Sub-module lane_steer (combinational) provides:
  - Store path: given word, addr[1:0], size and store data, produces the merged word.
  - Load path: given word, addr[1:0] and size, produces the right-aligned data.
- The top module keeps the FSM, counter, request latch and RAM array.

Test Plan:
- Reset, LATENCY=2: hold rst low, then release → ready=busy=err=0, ddt_out=0.
- Word store then load, LATENCY=2:
  - Store: mreq, write=1, dad=0x10, size=10, ddt_in=0xDEADBEEF → ready high exactly 3 cycles after acceptance.
  - Load of 0x10 → ddt_out=0xDEADBEEF, err=0.
- Sub-word stores:
  - Word 0x20 = 0x11223344; byte store 0xAA at 0x22 → load word 0x20 = 0x11AA3344.
  - Half store 0xBEEF at 0x20 → word 0x11AABEEF.
  - Byte load at 0x23 → 0x00000011.
- Misaligned word load at 0x21 and half store at 0x25 → ready with err=1, ddt_out=0; word 0x24 unchanged.
- Busy and zero-latency handling:
  - mreq held high during WAIT with a different dad → ignored; the original address is serviced.
  - LATENCY=0 build: ready one cycle after acceptance.
- Reset mid-WAIT during a store to 0x30 (previously 0x0) → FSM IDLE, no ready; load 0x30 → 0x00000000.
